// File: rtl/instr_issuer_pkg.sv
// Shared types and constants for the instruction issuer: instruction field layout,
// opcodes, idle word and FSM state encodings.
package instr_issuer_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_W    = 3;
    localparam int unsigned REG_W    = 3;

    localparam int unsigned OPC_LSB  = 13;
    localparam int unsigned SRCA_LSB = 10;
    localparam int unsigned SRCB_LSB = 7;
    localparam int unsigned DEST_LSB = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b010;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b011;

    localparam logic [INSTR_W-1:0] IDLE_WORD = 16'h0000;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [REG_W-1:0] dest;
        logic [3:0]       unused;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/instr_issuer_ram.sv
// Program buffer: DEPTH x INSTR_W, one synchronous write port, one asynchronous read port.
module instr_ram
    import instr_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata_c
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Issues a loaded program to a processor one word per cycle and accumulates the
// results that return RESULT_LAT edges after each issued instruction.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_en,
    input  logic [$clog2(DEPTH)-1:0]         load_addr,
    input  logic [INSTR_W-1:0]               load_data,
    input  logic [$clog2(DEPTH+1)-1:0]       prog_len,
    input  logic                             start,
    input  logic                             hold,
    input  logic [7:0]                       result,
    output logic [INSTR_W-1:0]               instruction,
    output logic                             instr_valid,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       last_result,
    output logic [7:0]                       result_sum,
    output logic [$clog2(DEPTH+1)-1:0]       result_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = RESULT_LAT;

    state_t          state_q, state_d;
    logic [CW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   len_q, len_d;
    logic [TW-1:0]   trk_q, trk_d;
    instr_t          instr_q, instr_d;
    logic            vld_q, vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      last_q, last_d;
    logic [7:0]      sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [CW-1:0]      len_eff;
    logic               ram_we;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;

    assign len_eff = (prog_len > CW'(DEPTH)) ? CW'(DEPTH) : prog_len;

    instr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (load_addr),
        .wdata   (load_data),
        .raddr   (rd_addr),
        .rdata_c (rd_data)
    );

    // Next-state, issue and result-capture logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_t'(IDLE_WORD);
        vld_d   = 1'b0;
        last_d  = last_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rd_addr = pc_q[AW-1:0];
        ram_we  = 1'b0;

        // Oldest tracking stage marks the cycle whose result is on the bus now.
        if (trk_q[TW-1]) begin
            last_d = result;
            sum_d  = sum_q + result;
            cnt_d  = cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                ram_we  = load_en;
                rd_addr = '0;
                if (start) begin
                    len_d  = len_eff;
                    last_d = '0;
                    sum_d  = '0;
                    cnt_d  = '0;
                    if (len_eff == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        instr_d = instr_t'(rd_data);
                        vld_d   = 1'b1;
                        pc_d    = CW'(1);
                        state_d = (len_eff == CW'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    instr_d = instr_t'(rd_data);
                    vld_d   = 1'b1;
                    pc_d    = pc_q + CW'(1);
                    if (pc_q == len_q - CW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (trk_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        trk_d  = (trk_q << 1) | TW'(vld_d);
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            trk_q   <= '0;
            instr_q <= instr_t'(IDLE_WORD);
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            trk_q   <= trk_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instruction  = instr_q;
    assign instr_valid  = vld_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign last_result  = last_q;
    assign result_sum   = sum_q;
    assign result_count = cnt_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a vector table for the main runs plus hand-written
// sequences for load/start collisions, busy noise, mid-run reset and full-length programs.
module tb_instr_issuer;
    import instr_issuer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        hold;
    logic [7:0]  result;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [7:0]  last_result;
    logic [7:0]  result_sum;
    logic [4:0]  result_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_issuer #(
        .DEPTH      (16),
        .RESULT_LAT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .prog_len     (prog_len),
        .start        (start),
        .hold         (hold),
        .result       (result),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .busy         (busy),
        .done         (done),
        .last_result  (last_result),
        .result_sum   (result_sum),
        .result_count (result_count)
    );

    typedef struct {
        logic        rst_n;
        logic        ld;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [4:0]  len;
        logic        st;
        logic        hd;
        logic [7:0]  res;
        logic [15:0] e_instr;
        logic        e_vld;
        logic        e_busy;
        logic        e_done;
        logic [4:0]  e_cnt;
        logic [7:0]  e_sum;
        logic [7:0]  e_last;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_mem [16];
    logic [15:0] w [4];
    logic [31:0] wd [4];

    function automatic logic [15:0] mkw(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] d);
        logic [15:0] x;
        x = '0;
        x[OPC_LSB  +: 3] = op;
        x[SRCA_LSB +: 3] = a;
        x[SRCB_LSB +: 3] = b;
        x[DEST_LSB +: 3] = d;
        return x;
    endfunction

    function automatic vec_t mkv(input logic [31:0] r, ld, a, d, l, st, hd, rs,
                                 input logic [31:0] ei, ev, eb, ed, ec, es, el);
        vec_t t;
        t.rst_n = r[0];   t.ld = ld[0];      t.addr = a[3:0];  t.data = d[15:0];
        t.len = l[4:0];   t.st = st[0];      t.hd = hd[0];     t.res = rs[7:0];
        t.e_instr = ei[15:0]; t.e_vld = ev[0]; t.e_busy = eb[0]; t.e_done = ed[0];
        t.e_cnt = ec[4:0]; t.e_sum = es[7:0]; t.e_last = el[7:0];
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a run, collect issued words until done, and compare against the buffer model.
    task automatic run_prog(input logic [4:0] len, input int exp_n, input bit noisy,
                            input string name);
        int nv = 0;
        bit seen_done = 0;
        prog_len = len;
        start    = 1'b1;
        result   = 8'd1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (instr_valid) begin
                check({name, "_word"}, 32'(instruction), 32'(exp_mem[nv % 16]));
                nv++;
            end
            if (done) begin
                seen_done = 1;
            end else begin
                if (noisy) begin
                    start     = 1'b1;
                    load_en   = 1'b1;
                    load_addr = 4'd1;
                    load_data = 16'hBEEF;
                    prog_len  = 5'd2;
                end
                tick;
            end
        end
        start   = 1'b0;
        load_en = 1'b0;
        check({name, "_done_seen"}, 32'(seen_done), 32'(1));
        check({name, "_issues"}, 32'(nv), 32'(exp_n));
        check({name, "_count"}, 32'(result_count), 32'(exp_n));
        check({name, "_sum"}, 32'(result_sum), 32'(exp_n));
        tick;
        check({name, "_done_1cyc"}, 32'(done), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; hold = 1'b0; result = '0;

        w[0] = mkw(OP_ADD, 3'd1, 3'd2, 3'd3);
        w[1] = mkw(OP_SUB, 3'd1, 3'd2, 3'd4);
        w[2] = mkw(OP_AND, 3'd3, 3'd1, 3'd5);
        w[3] = mkw(OP_OR,  3'd4, 3'd5, 3'd6);
        for (int i = 0; i < 4; i++) begin
            wd[i]      = 32'(w[i]);
            exp_mem[i] = w[i];
        end

        //                 rst ld a  data   len st hd res    instr  v  b  d  cnt sum last
        vecs.push_back(mkv(0,  0, 0, 0,      0, 0, 0, 0,     0,     0, 0, 0, 0,  0,   0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkv(1, 1, i, wd[i], 0, 0, 0, 0,   0,     0, 0, 0, 0,  0,   0));
        // basic 4-instruction run, results 1..4
        vecs.push_back(mkv(1,  0, 0, 0,      4, 1, 0, 0,     wd[0], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 11,    wd[1], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 1,     wd[2], 1, 1, 0, 1,  1,   1));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 2,     wd[3], 1, 1, 0, 2,  3,   2));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 3,     0,     0, 1, 0, 3,  6,   3));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 4,     0,     0, 1, 0, 4,  10,  4));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 99,    0,     0, 0, 1, 4,  10,  4));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 1, 99,    0,     0, 0, 0, 4,  10,  4));
        // hold for two cycles after the second issue, result 5 throughout
        vecs.push_back(mkv(1,  0, 0, 0,      4, 1, 0, 5,     wd[0], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     wd[1], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 1, 5,     0,     0, 1, 0, 1,  5,   5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 1, 5,     0,     0, 1, 0, 2,  10,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     wd[2], 1, 1, 0, 2,  10,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     wd[3], 1, 1, 0, 2,  10,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 1, 5,     0,     0, 1, 0, 3,  15,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     0,     0, 1, 0, 4,  20,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     0,     0, 0, 1, 4,  20,  5));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 5,     0,     0, 0, 0, 4,  20,  5));
        // prog_len=3 with result 200: sum wraps to 144 then 88
        vecs.push_back(mkv(1,  0, 0, 0,      3, 1, 0, 200,   wd[0], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   wd[1], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   wd[2], 1, 1, 0, 1,  200, 200));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   0,     0, 1, 0, 2,  144, 200));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   0,     0, 1, 0, 3,  88,  200));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   0,     0, 0, 1, 3,  88,  200));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 200,   0,     0, 0, 0, 3,  88,  200));
        // prog_len=0, then a start presented while in DONE is ignored
        vecs.push_back(mkv(1,  0, 0, 0,      0, 1, 0, 0,     0,     0, 0, 1, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      4, 1, 0, 0,     0,     0, 0, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 0,     0,     0, 0, 0, 0,  0,   0));
        // prog_len=1, result 7
        vecs.push_back(mkv(1,  0, 0, 0,      1, 1, 0, 7,     wd[0], 1, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 7,     0,     0, 1, 0, 0,  0,   0));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 7,     0,     0, 1, 0, 1,  7,   7));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 7,     0,     0, 0, 1, 1,  7,   7));
        vecs.push_back(mkv(1,  0, 0, 0,      0, 0, 0, 7,     0,     0, 0, 0, 1,  7,   7));

        foreach (vecs[i]) begin
            reset = vecs[i].rst_n; load_en = vecs[i].ld; load_addr = vecs[i].addr;
            load_data = vecs[i].data; prog_len = vecs[i].len; start = vecs[i].st;
            hold = vecs[i].hd; result = vecs[i].res;
            tick;
            check($sformatf("v%0d_instr", i), 32'(instruction), 32'(vecs[i].e_instr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_vld));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_count", i), 32'(result_count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_sum", i), 32'(result_sum), 32'(vecs[i].e_sum));
            check($sformatf("v%0d_last", i), 32'(last_result), 32'(vecs[i].e_last));
        end
        reset = 1'b1; load_en = 1'b0; start = 1'b0; hold = 1'b0; result = '0;

        // load and start on the same edge: the run sees the old mem[0]
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'h1234; prog_len = 5'd1; start = 1'b1;
        tick;
        load_en = 1'b0; start = 1'b0;
        check("ldst_old_word", 32'(instruction), 32'(exp_mem[0]));
        check("ldst_valid", 32'(instr_valid), 32'(1));
        exp_mem[0] = 16'h1234;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1;
            else tick;
        end
        check("ldst_done_seen", 32'(seen), 32'(1));
        tick;
        run_prog(5'd1, 1, 0, "ldst_new");
        load_en = 1'b1; load_addr = 4'd0; load_data = w[0];
        tick;
        load_en = 1'b0;
        exp_mem[0] = w[0];

        // load_en/start while busy must not disturb the run or the buffer
        run_prog(5'd4, 4, 1, "busy_noise");
        run_prog(5'd4, 4, 0, "after_noise");

        // reset after two issues aborts without a done pulse
        prog_len = 5'd4; start = 1'b1;
        tick;
        start = 1'b0;
        check("rst_pre_issue0", 32'(instruction), 32'(w[0]));
        tick;
        check("rst_pre_issue1", 32'(instruction), 32'(w[1]));
        reset = 1'b0;
        tick;
        check("rst_instr", 32'(instruction), 32'(0));
        check("rst_valid", 32'(instr_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_count", 32'(result_count), 32'(0));
        check("rst_sum", 32'(result_sum), 32'(0));
        check("rst_last", 32'(last_result), 32'(0));
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            check($sformatf("rst_quiet%0d", c), 32'({busy, done, instr_valid}), 32'(0));
        end
        run_prog(5'd4, 4, 0, "rerun");

        // full buffer; prog_len above 16 clamps to 16
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = mkw(3'(i % 4), 3'(i % 8), 3'((i + 1) % 8), 3'((i + 2) % 8));
            load_en = 1'b1; load_addr = 4'(i); load_data = exp_mem[i];
            tick;
        end
        load_en = 1'b0;
        run_prog(5'd31, 16, 0, "len31");
        run_prog(5'd16, 16, 0, "len16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
